// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-master memory port arbiter: controller
// state encoding, access-size codes, the latched command record and the
// default data word returned when a read is abandoned.
package mem_arb_pkg;

   // Controller states: waiting for a request, driving a command, waiting for read data
   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_WAIT_DATA = 2'd2
   } arb_state_e;

   // Access size codes carried unchanged from requester to memory
   localparam logic [1:0] MEM_SIZE_BYTE = 2'd1;
   localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

   // Read data handed back when the memory never answers
   localparam logic [15:0] TIMEOUT_DATA_DFLT = 16'hFFFF;

   // One memory command as captured at accept time
   typedef struct packed {
      logic        write;
      logic [1:0]  size;
      logic [15:0] addr;
      logic [15:0] wdata;
   } mem_cmd_t;

   // Bundle a requester's loose request fields into a command record
   function automatic mem_cmd_t make_cmd(input logic        write,
                                         input logic [1:0]  size,
                                         input logic [15:0] addr,
                                         input logic [15:0] wdata);
      mem_cmd_t cmd;
      cmd.write = write;
      cmd.size  = size;
      cmd.addr  = addr;
      cmd.wdata = wdata;
      return cmd;
   endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way combinational winner select. A lone requester always wins; on a
// tie the winner is requester 0 in fixed-priority mode, otherwise whichever
// requester did not win last time. With nobody requesting, both readies are
// offered so a newly arriving request is taken without a wasted cycle.
module arb_rr2 #(
   parameter int FIXED_PRIO = 0
) (
   input  logic [1:0] exec_i,
   input  logic       last_grant_i,
   output logic       grant_o,
   output logic [1:0] ready_o
);

   logic tie_winner;

   // Tie-break: fixed priority favours requester 0, round-robin favours the one not served last
   assign tie_winner = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_i;

   // Winner and per-requester ready from the current request pattern
   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
      grant_o = 1'b0;
      ready_o = 2'b11;
      unique case (exec_i)
         2'b00: begin
            grant_o = 1'b0;
            ready_o = 2'b11;
         end
         2'b01: begin
            grant_o = 1'b0;
            ready_o = 2'b01;
         end
         2'b10: begin
            grant_o = 1'b1;
            ready_o = 2'b10;
         end
         default: begin
            grant_o = tie_winner;
            ready_o = tie_winner ? 2'b10 : 2'b01;
         end
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single external memory port between the core (requester 0)
// and the DMA/peripheral master (requester 1). One transaction is in flight
// at a time: it is accepted in IDLE, replayed on MEM_* during ISSUE until the
// memory takes it, and for reads the answer (or a timeout word) is routed
// back to the requester that owns the transaction.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int          FIXED_PRIO   = 0,
   parameter int          TIMEOUT      = 255,
   parameter logic [15:0] TIMEOUT_DATA = TIMEOUT_DATA_DFLT
) (
   input  logic        I_clk,
   input  logic        I_reset,
   // requester 0 (core side)
   input  logic        R0_exec,
   input  logic        R0_write,
   input  logic [1:0]  R0_size,
   input  logic [15:0] R0_addr,
   input  logic [15:0] R0_wdata,
   output logic        R0_ready,
   output logic [15:0] R0_data,
   output logic        R0_data_ready,
   // requester 1 (DMA / peripheral master)
   input  logic        R1_exec,
   input  logic        R1_write,
   input  logic [1:0]  R1_size,
   input  logic [15:0] R1_addr,
   input  logic [15:0] R1_wdata,
   output logic        R1_ready,
   output logic [15:0] R1_data,
   output logic        R1_data_ready,
   // external memory port
   input  logic        MEM_ready,
   output logic        MEM_exec,
   output logic        MEM_write,
   output logic [1:0]  MEM_size,
   output logic [15:0] MEM_addr,
   output logic [15:0] MEM_data_out,
   input  logic [15:0] MEM_data_in,
   input  logic        MEM_data_ready,
   // status
   output logic        O_grant,
   output logic        O_busy,
   output logic        O_timeout
);

   // Last counter value spent in WAIT_DATA before the read is abandoned
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

   arb_state_e  state_q, state_d;
   logic        last_grant_q, last_grant_d;
   logic        grant_q, grant_d;
   mem_cmd_t    cmd_q, cmd_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] r0_data_q, r0_data_d;
   logic [15:0] r1_data_q, r1_data_d;
   logic        r0_dv_q, r0_dv_d;
   logic        r1_dv_q, r1_dv_d;
   logic        tmo_q, tmo_d;

   logic [1:0]  req_exec;
   logic [1:0]  arb_ready;
   logic        arb_grant;
   logic        accept;
   logic        done;
   logic [15:0] done_data;
   mem_cmd_t    r0_cmd, r1_cmd;

   assign req_exec = {R1_exec, R0_exec};
   assign r0_cmd   = make_cmd(R0_write, R0_size, R0_addr, R0_wdata);
   assign r1_cmd   = make_cmd(R1_write, R1_size, R1_addr, R1_wdata);

   arb_rr2 #(
      .FIXED_PRIO (FIXED_PRIO)
   ) u_arb (
      .exec_i       (req_exec),
      .last_grant_i (last_grant_q),
      .grant_o      (arb_grant),
      .ready_o      (arb_ready)
   );

   // Requests are only offered while no transaction is in flight
   assign R0_ready = (state_q == ST_IDLE) & arb_ready[0];
   assign R1_ready = (state_q == ST_IDLE) & arb_ready[1];
   assign accept   = (state_q == ST_IDLE) & |(req_exec & arb_ready);

   // Next-state, command capture, timeout counting and read-data routing
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      cmd_d        = cmd_q;
      cnt_d        = cnt_q;
      r0_data_d    = r0_data_q;
      r1_data_d    = r1_data_q;
      r0_dv_d      = 1'b0;
      r1_dv_d      = 1'b0;
      tmo_d        = 1'b0;
      done         = 1'b0;
      done_data    = MEM_data_in;

      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               grant_d      = arb_grant;
               last_grant_d = arb_grant;
               cmd_d        = arb_grant ? r1_cmd : r0_cmd;
               state_d      = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            // Command stays on the bus untouched until the memory takes it
            if (MEM_ready) begin
               state_d = cmd_q.write ? ST_IDLE : ST_WAIT_DATA;
               cnt_d   = '0;
            end
         end
         ST_WAIT_DATA: begin
            // Real data in the last allowed cycle still wins over the timeout
            if (MEM_data_ready) begin
               done      = 1'b1;
               done_data = MEM_data_in;
            end else if (cnt_q == TIMEOUT_LAST) begin
               done      = 1'b1;
               done_data = TIMEOUT_DATA;
               tmo_d     = 1'b1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Only the owner of the transaction sees new data; the other side holds
      if (done) begin
         state_d = ST_IDLE;
         if (grant_q) begin
            r1_data_d = done_data;
            r1_dv_d   = 1'b1;
         end else begin
            r0_data_d = done_data;
            r0_dv_d   = 1'b1;
         end
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge I_clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (I_reset) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b1;
         grant_q      <= 1'b0;
         cmd_q        <= '0;
         cnt_q        <= '0;
         r0_data_q    <= '0;
         r1_data_q    <= '0;
         r0_dv_q      <= 1'b0;
         r1_dv_q      <= 1'b0;
         tmo_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         cmd_q        <= cmd_d;
         cnt_q        <= cnt_d;
         r0_data_q    <= r0_data_d;
         r1_data_q    <= r1_data_d;
         r0_dv_q      <= r0_dv_d;
         r1_dv_q      <= r1_dv_d;
         tmo_q        <= tmo_d;
      end
   end

   assign MEM_exec      = (state_q == ST_ISSUE);
   assign MEM_write     = cmd_q.write;
   assign MEM_size      = cmd_q.size;
   assign MEM_addr      = cmd_q.addr;
   assign MEM_data_out  = cmd_q.wdata;

   assign R0_data       = r0_data_q;
   assign R1_data       = r1_data_q;
   assign R0_data_ready = r0_dv_q;
   assign R1_data_ready = r1_dv_q;

   assign O_grant       = grant_q;
   assign O_busy        = (state_q != ST_IDLE);
   assign O_timeout     = tmo_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter. Two instances run side by side:
// instance 0 is round-robin with a 4-cycle read timeout, instance 1 is
// fixed-priority with a 7-cycle timeout. Each instance has its own pair of
// random masters (requests held until accepted) and a random memory that
// stalls, answers late, answers never, and sends stray data. A
// transaction-level reference model predicts every output each cycle.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   logic clk;
   logic rst;

   // per-instance stimulus
   logic        exec_i   [2][2];
   logic        write_i  [2][2];
   logic [1:0]  size_i   [2][2];
   logic [15:0] addr_i   [2][2];
   logic [15:0] wdata_i  [2][2];
   logic        mem_ready_i [2];
   logic        mem_dv_i    [2];
   logic [15:0] mem_din_i   [2];

   // per-instance observed outputs
   logic        ready_o  [2][2];
   logic [15:0] data_o   [2][2];
   logic        dv_o     [2][2];
   logic        mem_exec_o  [2];
   logic        mem_write_o [2];
   logic [1:0]  mem_size_o  [2];
   logic [15:0] mem_addr_o  [2];
   logic [15:0] mem_dout_o  [2];
   logic        grant_o [2];
   logic        busy_o  [2];
   logic        tmo_o   [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      mem_arbiter #(
         .FIXED_PRIO   (g),
         .TIMEOUT      ((g == 0) ? 4 : 7),
         .TIMEOUT_DATA (16'hFFFF)
      ) u_dut (
         .I_clk          (clk),
         .I_reset        (rst),
         .R0_exec        (exec_i[g][0]),
         .R0_write       (write_i[g][0]),
         .R0_size        (size_i[g][0]),
         .R0_addr        (addr_i[g][0]),
         .R0_wdata       (wdata_i[g][0]),
         .R0_ready       (ready_o[g][0]),
         .R0_data        (data_o[g][0]),
         .R0_data_ready  (dv_o[g][0]),
         .R1_exec        (exec_i[g][1]),
         .R1_write       (write_i[g][1]),
         .R1_size        (size_i[g][1]),
         .R1_addr        (addr_i[g][1]),
         .R1_wdata       (wdata_i[g][1]),
         .R1_ready       (ready_o[g][1]),
         .R1_data        (data_o[g][1]),
         .R1_data_ready  (dv_o[g][1]),
         .MEM_ready      (mem_ready_i[g]),
         .MEM_exec       (mem_exec_o[g]),
         .MEM_write      (mem_write_o[g]),
         .MEM_size       (mem_size_o[g]),
         .MEM_addr       (mem_addr_o[g]),
         .MEM_data_out   (mem_dout_o[g]),
         .MEM_data_in    (mem_din_i[g]),
         .MEM_data_ready (mem_dv_i[g]),
         .O_grant        (grant_o[g]),
         .O_busy         (busy_o[g]),
         .O_timeout      (tmo_o[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- masters: pending request per requester ----------------
   bit          p_pend  [2][2];
   bit          p_write [2][2];
   logic [1:0]  p_size  [2][2];
   logic [15:0] p_addr  [2][2];
   logic [15:0] p_wdata [2][2];

   // ---------------- reference model (transaction level) ----------------
   bit          m_have   [2];     // a transaction is owned by the arbiter
   bit          m_issued [2];     // memory has taken the command, read outstanding
   int          m_waited [2];     // cycles already spent waiting for read data
   bit          m_last   [2];     // requester that won most recently
   bit          m_grant  [2];
   bit          m_write  [2];
   logic [1:0]  m_size   [2];
   logic [15:0] m_addr   [2];
   logic [15:0] m_wdata  [2];
   logic [15:0] m_rdata  [2][2];
   bit          m_rdv    [2][2];
   bit          m_tmo    [2];

   function automatic int tmo_limit(input int m);
      return (m == 0) ? 4 : 7;
   endfunction

   // Which requester is allowed in, given who is asking right now
   function automatic logic [1:0] exp_ready(input int m);
      if (m_have[m]) return 2'b00;
      if (!p_pend[m][0] && !p_pend[m][1]) return 2'b11;
      if (p_pend[m][0] && !p_pend[m][1]) return 2'b01;
      if (!p_pend[m][0] && p_pend[m][1]) return 2'b10;
      if (m == 1) return 2'b01;                  // fixed priority: core first
      return (m_last[m] == 1'b1) ? 2'b01 : 2'b10; // round-robin: the one not served last
   endfunction

   task automatic model_reset(input int m);
      m_have[m]   = 0;
      m_issued[m] = 0;
      m_waited[m] = 0;
      m_last[m]   = 1;
      m_grant[m]  = 0;
      m_write[m]  = 0;
      m_size[m]   = '0;
      m_addr[m]   = '0;
      m_wdata[m]  = '0;
      m_tmo[m]    = 0;
      for (int r = 0; r < 2; r++) begin
         m_rdata[m][r] = '0;
         m_rdv[m][r]   = 0;
      end
   endtask

   task automatic deliver(input int m, input logic [15:0] d, input bit timed_out);
      m_rdata[m][m_grant[m]] = d;
      m_rdv[m][m_grant[m]]   = 1;
      m_tmo[m]               = timed_out;
      m_have[m]              = 0;
   endtask

   // Advance the model across one clock edge using the inputs now applied
   task automatic model_step(input int m);
      logic [1:0] rdy;
      if (rst) begin
         model_reset(m);
         return;
      end
      m_rdv[m][0] = 0;
      m_rdv[m][1] = 0;
      m_tmo[m]    = 0;
      if (!m_have[m]) begin
         rdy = exp_ready(m);
         for (int r = 0; r < 2; r++) begin
            if (p_pend[m][r] && rdy[r]) begin
               m_have[m]   = 1;
               m_issued[m] = 0;
               m_grant[m]  = r[0];
               m_last[m]   = r[0];
               m_write[m]  = p_write[m][r];
               m_size[m]   = p_size[m][r];
               m_addr[m]   = p_addr[m][r];
               m_wdata[m]  = p_wdata[m][r];
               p_pend[m][r] = 0;
            end
         end
      end else if (!m_issued[m]) begin
         if (mem_ready_i[m]) begin
            if (m_write[m]) m_have[m] = 0;
            else begin
               m_issued[m] = 1;
               m_waited[m] = 0;
            end
         end
      end else begin
         m_waited[m]++;
         if (mem_dv_i[m]) deliver(m, mem_din_i[m], 0);
         else if (m_waited[m] == tmo_limit(m)) deliver(m, 16'hFFFF, 1);
      end
   endtask

   // ---------------- checks ----------------
   task automatic check_regs(input int m);
      check($sformatf("i%0d R0_data", m),       data_o[m][0],  m_rdata[m][0]);
      check($sformatf("i%0d R1_data", m),       data_o[m][1],  m_rdata[m][1]);
      check($sformatf("i%0d R0_data_ready", m), dv_o[m][0],    m_rdv[m][0]);
      check($sformatf("i%0d R1_data_ready", m), dv_o[m][1],    m_rdv[m][1]);
      check($sformatf("i%0d O_timeout", m),     tmo_o[m],      m_tmo[m]);
      check($sformatf("i%0d O_grant", m),       grant_o[m],    m_grant[m]);
      check($sformatf("i%0d MEM_write", m),     mem_write_o[m], m_write[m]);
      check($sformatf("i%0d MEM_size", m),      mem_size_o[m], m_size[m]);
      check($sformatf("i%0d MEM_addr", m),      mem_addr_o[m], m_addr[m]);
      check($sformatf("i%0d MEM_data_out", m),  mem_dout_o[m], m_wdata[m]);
   endtask

   task automatic check_comb(input int m);
      logic [1:0] rdy;
      rdy = exp_ready(m);
      check($sformatf("i%0d R0_ready", m), ready_o[m][0], rdy[0]);
      check($sformatf("i%0d R1_ready", m), ready_o[m][1], rdy[1]);
      check($sformatf("i%0d MEM_exec", m), mem_exec_o[m], m_have[m] && !m_issued[m]);
      check($sformatf("i%0d O_busy", m),   busy_o[m],     m_have[m]);
   endtask

   // ---------------- stimulus ----------------
   task automatic drive(input int req_pct, input int rdy_pct, input int dv_pct);
      rst = ($urandom_range(0, 249) == 0);
      for (int m = 0; m < 2; m++) begin
         for (int r = 0; r < 2; r++) begin
            if (!p_pend[m][r] && ($urandom_range(0, 99) < req_pct)) begin
               p_pend[m][r]  = 1;
               p_write[m][r] = $urandom_range(0, 1) == 1;
               p_size[m][r]  = ($urandom_range(0, 1) == 1) ? MEM_SIZE_WORD : MEM_SIZE_BYTE;
               p_addr[m][r]  = 16'($urandom);
               p_wdata[m][r] = 16'($urandom);
            end
            exec_i[m][r]  = p_pend[m][r];
            write_i[m][r] = p_write[m][r];
            size_i[m][r]  = p_size[m][r];
            addr_i[m][r]  = p_addr[m][r];
            wdata_i[m][r] = p_wdata[m][r];
         end
         mem_ready_i[m] = ($urandom_range(0, 99) < rdy_pct);
         mem_dv_i[m]    = ($urandom_range(0, 99) < dv_pct);
         mem_din_i[m]   = 16'($urandom);
      end
   endtask

   // Phase mixes: busy traffic, heavy back-pressure, silent memory, fast memory
   int req_pct_t [4] = '{60, 95, 30, 90};
   int rdy_pct_t [4] = '{80, 30, 100, 60};
   int dv_pct_t  [4] = '{40, 20, 0, 60};

   initial begin
      rst = 1'b1;
      for (int m = 0; m < 2; m++) begin
         for (int r = 0; r < 2; r++) begin
            p_pend[m][r]  = 0;
            p_write[m][r] = 0;
            p_size[m][r]  = '0;
            p_addr[m][r]  = '0;
            p_wdata[m][r] = '0;
            exec_i[m][r]  = 1'b0;
            write_i[m][r] = 1'b0;
            size_i[m][r]  = '0;
            addr_i[m][r]  = '0;
            wdata_i[m][r] = '0;
         end
         mem_ready_i[m] = 1'b0;
         mem_dv_i[m]    = 1'b0;
         mem_din_i[m]   = '0;
         model_reset(m);
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      for (int ph = 0; ph < 4; ph++) begin
         for (int cyc = 0; cyc < 600; cyc++) begin
            for (int m = 0; m < 2; m++) check_regs(m);
            drive(req_pct_t[ph], rdy_pct_t[ph], dv_pct_t[ph]);
            #1;
            for (int m = 0; m < 2; m++) check_comb(m);
            for (int m = 0; m < 2; m++) model_step(m);
            @(posedge clk);
            #1;
         end
      end
      for (int m = 0; m < 2; m++) check_regs(m);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
